// File: rtl/keypad_event_gen.sv
// keypad_event_gen: 4x4 matrix keypad scanner with per-key debounce and press events; AUTO_REPEAT_EN adds a held-key auto-repeat tracker
module keypad_event_gen #(
  parameter int SCAN_DIV      = 50000,
  parameter int DB_SAMPLES    = 5,
  parameter int REPEAT_DELAY  = 125,
  parameter int REPEAT_PERIOD = 25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  col,
  output logic [3:0]  row,
  output logic [15:0] key_level,
  output logic [15:0] key_pulse,
  output logic        key_valid,
  output logic [3:0]  key_code
);
  localparam int DW = $clog2(SCAN_DIV);
  logic [DW-1:0] div;
  logic [1:0]    r;
  logic [3:0]    col_m, col_s, smp;
  logic [3:0]    cnt [16];
  logic [3:0]    cnt_nxt [16];
  logic [15:0]   lvl_nxt, rise, fire, pulse_nxt;
  logic          tick;
  function automatic logic [3:0] lowest(input logic [15:0] m);
    lowest = '0;
    for (int i = 15; i >= 0; i--) if (m[i]) lowest = 4'(i);
  endfunction
  assign tick      = div == DW'(SCAN_DIV - 1);
  assign smp       = ~col_s;
  assign rise      = tick ? lvl_nxt & ~key_level : '0;
  assign pulse_nxt = rise | fire;
  // two-flop synchronizer on the column inputs; idle columns read high
  always_ff @(posedge clk or posedge reset)
    if (reset) {col_s, col_m} <= '1;
    else {col_s, col_m} <= {col_m, col};
  // scan divider and registered one-hot-low row drive, advanced on each tick
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      div <= '0;
      r   <= '0;
      row <= 4'b1110;
    end else begin
      div <= tick ? '0 : div + DW'(1);
      if (tick) begin
        r   <= r + 2'd1;
        row <= ~(4'b0001 << (r + 2'd1));
      end
    end
  // debounce update for the four keys of the row currently being sampled
  always_comb begin
    lvl_nxt = key_level;
    for (int k = 0; k < 16; k++) cnt_nxt[k] = cnt[k];
    for (int c = 0; c < 4; c++)
      if (smp[c] == key_level[{r, 2'(c)}]) cnt_nxt[{r, 2'(c)}] = '0;
      else if (cnt[{r, 2'(c)}] + 4'd1 == 4'(DB_SAMPLES)) begin
        lvl_nxt[{r, 2'(c)}] = smp[c];
        cnt_nxt[{r, 2'(c)}] = '0;
      end else cnt_nxt[{r, 2'(c)}] = cnt[{r, 2'(c)}] + 4'd1;
  end
`ifdef AUTO_REPEAT_EN
  logic        trk, rep_first, row_hit, fire_now;
  logic [3:0]  trk_code;
  logic [15:0] rep_cnt, lim;
  assign row_hit  = tick && trk && r == trk_code[3:2];
  assign lim      = rep_first ? 16'(REPEAT_DELAY) : 16'(REPEAT_PERIOD);
  assign fire_now = row_hit && ~|rise && lvl_nxt[trk_code] && smp[trk_code[1:0]] && rep_cnt + 16'd1 >= lim;
  assign fire     = fire_now ? 16'b1 << trk_code : '0;
  // repeat tracker: counts frames on the tracked key's row tick, only repeats while the key is physically down
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      trk       <= 1'b0;
      trk_code  <= '0;
      rep_cnt   <= '0;
      rep_first <= 1'b0;
    end else if (|rise) begin
      trk       <= 1'b1;
      trk_code  <= lowest(rise);
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (row_hit) begin
      if (!lvl_nxt[trk_code]) trk <= 1'b0;
      else if (fire_now) begin
        rep_cnt   <= '0;
        rep_first <= 1'b0;
      end else rep_cnt <= rep_cnt + 16'd1;
    end
`else
  assign fire = '0;
`endif
  // debounced state commit on ticks and one-cycle event outputs
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      key_level <= '0;
      key_pulse <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      for (int k = 0; k < 16; k++) cnt[k] <= '0;
    end else begin
      key_pulse <= pulse_nxt;
      key_valid <= |pulse_nxt;
      if (|pulse_nxt) key_code <= lowest(pulse_nxt);
      if (tick) begin
        key_level <= lvl_nxt;
        for (int k = 0; k < 16; k++) cnt[k] <= cnt_nxt[k];
      end
    end
endmodule

// File: tb/tb_keypad_event_gen.sv
// tb_keypad_event_gen: scoreboard bench for keypad_event_gen with SCAN_DIV=4, DB_SAMPLES=3
module tb_keypad_event_gen;
  logic        clk = 0, reset = 1;
  logic [3:0]  col, row, key_code;
  logic [15:0] key_level, key_pulse;
  logic        key_valid;
  logic [15:0] pressed = '0;
  int          ecount, errors = 0, checks = 0;
  typedef struct {int edge_n; logic [15:0] pulse; logic [3:0] code;} ev_t;
  ev_t sb[$];

  keypad_event_gen #(.SCAN_DIV(4), .DB_SAMPLES(3), .REPEAT_DELAY(4), .REPEAT_PERIOD(2)) dut (
    .clk(clk), .reset(reset), .col(col), .row(row), .key_level(key_level),
    .key_pulse(key_pulse), .key_valid(key_valid), .key_code(key_code));

  always #5 clk = ~clk;

  // keypad matrix: a pressed key pulls its column low while its row is driven low
  always_comb begin
    col = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++)
        if (!row[rr] && pressed[rr*4+c]) col[c] = 1'b0;
  end

  always @(posedge clk or posedge reset)
    if (reset) ecount <= 0;
    else ecount <= ecount + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, ecount);
    end
  endtask

  // first tick strictly after tick-aligned edge e that samples row r (tick k samples row (k-1)%4)
  function automatic int next_row_tick(input int e, input int r);
    int n = e + 4;
    while (((n / 4) - 1) % 4 != r) n += 4;
    return n;
  endfunction

  task automatic wait_edge(input int n);
    while (ecount < n) @(negedge clk);
  endtask

  task automatic align();
    do @(negedge clk); while (ecount % 4 != 0);
  endtask

  // monitor: pop and compare on every presented event, flag late or spurious events
  always @(negedge clk) begin : mon
    ev_t e;
    if (!reset) begin
      if (key_valid || key_pulse != 16'h0) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got pulse=%h valid=%b expected none (edge %0d)", key_pulse, key_valid, ecount);
        end else begin
          e = sb.pop_front();
          check("pulse", key_pulse, e.pulse);
          check("valid", key_valid, 1);
          check("code", key_code, e.code);
          check("event_edge", ecount, e.edge_n);
        end
      end else if (sb.size() > 0 && ecount > sb[0].edge_n) begin
        e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_event: got none expected pulse=%h by edge %0d", e.pulse, e.edge_n);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n1;
    logic [3:0] rexp;
    repeat (2) @(negedge clk);
    reset = 0;
    check("rst_row", row, 4'b1110);
    check("rst_level", key_level, 0);
    check("rst_pulse", key_pulse, 0);
    check("rst_valid", key_valid, 0);
    check("rst_code", key_code, 0);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      rexp = ~(4'b0001 << ((i / 4) % 4));
      check("row_scan", row, rexp);
    end
    // key 6 held clean, then released
    align();
    n1 = next_row_tick(ecount, 1);
    pressed[6] = 1;
    sb.push_back('{n1 + 32, 16'h0040, 4'd6});
    wait_edge(n1 + 40);
    check("k6_level_held", key_level, 16'h0040);
    check("k6_sb_drained", sb.size(), 0);
    align();
    pressed[6] = 0;
    wait_edge(ecount + 64);
    check("k6_level_released", key_level, 0);
    // key 9 bouncing for five frames, then stable
    align();
    n1 = next_row_tick(ecount, 2);
    sb.push_back('{n1 + 96, 16'h0200, 4'd9});
    for (int i = 0; i < 5; i++) begin
      pressed[9] = (i % 2 == 0);
      wait_edge(ecount + 16);
    end
    wait_edge(n1 + 100);
    check("k9_level", key_level, 16'h0200);
    check("k9_sb_drained", sb.size(), 0);
    align();
    pressed[9] = 0;
    wait_edge(ecount + 64);
    check("k9_level_released", key_level, 0);
    // keys 4 and 7 on the same frame
    align();
    n1 = next_row_tick(ecount, 1);
    pressed[4] = 1;
    pressed[7] = 1;
    sb.push_back('{n1 + 32, 16'h0090, 4'd4});
    wait_edge(n1 + 40);
    check("k47_level", key_level, 16'h0090);
    check("k47_sb_drained", sb.size(), 0);
    // reset while keys 4/7 are held and key 0 is mid-count
    align();
    pressed[0] = 1;
    n1 = next_row_tick(ecount, 0);
    wait_edge(n1 + 4);
    #2 reset = 1;
    #1;
    check("async_level", key_level, 0);
    check("async_code", key_code, 0);
    check("async_row", row, 4'b1110);
    check("async_pulse", key_pulse, 0);
    check("async_valid", key_valid, 0);
    pressed[4] = 0;
    pressed[7] = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    sb.push_back('{36, 16'h0001, 4'd0});
    wait_edge(44);
    check("k0_level", key_level, 16'h0001);
    check("k0_sb_drained", sb.size(), 0);
    align();
    pressed[0] = 0;
    wait_edge(ecount + 64);
    check("k0_level_released", key_level, 0);
`ifdef AUTO_REPEAT_EN
    // key 1 held through eleven samples: pulses on samples 3, 7, 9, 11
    align();
    n1 = next_row_tick(ecount, 0);
    pressed[1] = 1;
    sb.push_back('{n1 + 32, 16'h0002, 4'd1});
    sb.push_back('{n1 + 96, 16'h0002, 4'd1});
    sb.push_back('{n1 + 128, 16'h0002, 4'd1});
    sb.push_back('{n1 + 160, 16'h0002, 4'd1});
    wait_edge(n1 + 160);
    pressed[1] = 0;
    wait_edge(ecount + 96);
    check("rep_level_released", key_level, 0);
    check("rep_sb_drained", sb.size(), 0);
`endif
    wait_edge(ecount + 32);
    check("final_sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
